// File: rtl/flash_playback_ctrl_if.sv
// Command and status bundle between the keyboard decoder, flash reader and playback controller.
// The master side issues commands and step requests; the slave side is the controller.
interface flash_playback_ctrl_if #(
    parameter int ADDR_W = 23,
    parameter int DIV_W  = 16
);
    logic              i_kb_play;
    logic              i_kb_pause;
    logic              i_kb_fwd;
    logic              i_kb_bwd;
    logic              i_kb_restart;
    logic              i_spd_up;
    logic              i_spd_down;
    logic              i_spd_reset;
    logic              i_address_inc;
    logic              i_address_dec;
    logic              i_address_rst;
    logic [ADDR_W-1:0] o_flash_address;
    logic              o_sample_tick;
    logic              o_playing;
    logic              o_direction;
    logic [DIV_W-1:0]  o_divisor;

    modport master (
        output i_kb_play, i_kb_pause, i_kb_fwd, i_kb_bwd, i_kb_restart,
        output i_spd_up, i_spd_down, i_spd_reset,
        output i_address_inc, i_address_dec, i_address_rst,
        input  o_flash_address, o_sample_tick, o_playing, o_direction, o_divisor
    );

    modport slave (
        input  i_kb_play, i_kb_pause, i_kb_fwd, i_kb_bwd, i_kb_restart,
        input  i_spd_up, i_spd_down, i_spd_reset,
        input  i_address_inc, i_address_dec, i_address_rst,
        output o_flash_address, o_sample_tick, o_playing, o_direction, o_divisor
    );
endinterface

// File: rtl/flash_playback_ctrl.sv
// Flash audio playback sequencer: owns the flash word address, sample-rate tick, play state and speed.
// Define PLAYBACK_LOOP_EN to wrap the address at the image ends instead of stopping playback.
module flash_playback_ctrl #(
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR   = 23'h7FFFF,
    parameter int                DIV_W       = 16,
    parameter logic [DIV_W-1:0]  DIV_DEFAULT = 16'd1136,
    parameter logic [DIV_W-1:0]  DIV_STEP    = 16'd64,
    parameter logic [DIV_W-1:0]  DIV_MIN     = 16'd284,
    parameter logic [DIV_W-1:0]  DIV_MAX     = 16'd4544
) (
    input  logic                 clk,
    input  logic                 rst,
    flash_playback_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_PAUSE = 1'b0,
        ST_PLAY  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ZERO    = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  DIV_ZERO     = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE      = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W:0]    DIV_DN_LIMIT = {1'b0, DIV_MIN} + {1'b0, DIV_STEP};

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [ADDR_W-1:0]  w_start;
    logic               w_step;
    logic               w_toward_last;
    logic               w_hit_end;
    logic               r_dir;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [DIV_W:0]     w_div_sum;
    logic [DIV_W-1:0]   r_count;
    logic               r_tick;

    // Play/pause state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_PAUSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: pause and an unlooped end-of-image both override play
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PAUSE: begin
                if (bus.i_kb_play && !bus.i_kb_pause && !w_hit_end) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PLAY: begin
                if (bus.i_kb_pause || w_hit_end) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            default: w_state_nxt = ST_PAUSE;
        endcase
    end

    // Next address: restart/reader reset, then a single step in or against the playback direction
    always_comb begin
        w_addr_nxt    = r_addr;
        w_hit_end     = 1'b0;
        w_start       = r_dir ? ADDR_ZERO : LAST_ADDR;
        w_step        = bus.i_address_inc ^ bus.i_address_dec;
        w_toward_last = (bus.i_address_inc & r_dir) | (bus.i_address_dec & ~r_dir);
        if (bus.i_kb_restart || bus.i_address_rst) begin
            w_addr_nxt = w_start;
        end else if (w_step && w_toward_last) begin
            if (r_addr == LAST_ADDR) begin
`ifdef PLAYBACK_LOOP_EN
                w_addr_nxt = ADDR_ZERO;
`else
                w_hit_end  = 1'b1;
`endif
            end else begin
                w_addr_nxt = r_addr + ADDR_ONE;
            end
        end else if (w_step) begin
            if (r_addr == ADDR_ZERO) begin
`ifdef PLAYBACK_LOOP_EN
                w_addr_nxt = LAST_ADDR;
`else
                w_hit_end  = 1'b1;
`endif
            end else begin
                w_addr_nxt = r_addr - ADDR_ONE;
            end
        end else begin
            w_addr_nxt = r_addr;
        end
    end

    // Address and direction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= ADDR_ZERO;
            r_dir  <= 1'b1;
        end else begin
            r_addr <= w_addr_nxt;
            if (bus.i_kb_fwd && !bus.i_kb_bwd) begin
                r_dir <= 1'b1;
            end else if (bus.i_kb_bwd && !bus.i_kb_fwd) begin
                r_dir <= 1'b0;
            end else begin
                r_dir <= r_dir;
            end
        end
    end

    // Next divisor: reset wins, opposing commands cancel, results saturate at the limits
    always_comb begin
        w_div_nxt = r_div;
        w_div_sum = {1'b0, r_div} + {1'b0, DIV_STEP};
        if (bus.i_spd_reset) begin
            w_div_nxt = DIV_DEFAULT;
        end else if (bus.i_spd_up && !bus.i_spd_down) begin
            if ({1'b0, r_div} >= DIV_DN_LIMIT) begin
                w_div_nxt = r_div - DIV_STEP;
            end else begin
                w_div_nxt = DIV_MIN;
            end
        end else if (bus.i_spd_down && !bus.i_spd_up) begin
            if (w_div_sum > {1'b0, DIV_MAX}) begin
                w_div_nxt = DIV_MAX;
            end else begin
                w_div_nxt = w_div_sum[DIV_W-1:0];
            end
        end else begin
            w_div_nxt = r_div;
        end
    end

    // Divisor register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= DIV_DEFAULT;
        end else begin
            r_div <= w_div_nxt;
        end
    end

    // Sample divider: >= so a divisor shrunk below the running count still fires promptly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= DIV_ZERO;
            r_tick  <= 1'b0;
        end else if (r_state == ST_PLAY) begin
            if (r_count >= (r_div - DIV_ONE)) begin
                r_count <= DIV_ZERO;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + DIV_ONE;
                r_tick  <= 1'b0;
            end
        end else begin
            r_count <= r_count;
            r_tick  <= 1'b0;
        end
    end

    assign bus.o_flash_address = r_addr;
    assign bus.o_sample_tick   = r_tick;
    assign bus.o_playing       = (r_state == ST_PLAY);
    assign bus.o_direction     = r_dir;
    assign bus.o_divisor       = r_div;

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Self-checking bench for flash_playback_ctrl: scenario tasks with a queue of expected results.
module tb_flash_playback_ctrl;

    localparam int          ADDR_W = 23;
    localparam int          DIV_W  = 16;
    localparam logic [22:0] LAST   = 23'h7FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    flash_playback_ctrl_if #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) bus ();

    flash_playback_ctrl #(
        .ADDR_W(ADDR_W), .LAST_ADDR(LAST), .DIV_W(DIV_W),
        .DIV_DEFAULT(16'd1136), .DIV_STEP(16'd64), .DIV_MIN(16'd284), .DIV_MAX(16'd4544)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_kb_play = 1'b0;  bus.i_kb_pause = 1'b0;  bus.i_kb_fwd = 1'b0;
        bus.i_kb_bwd = 1'b0;   bus.i_kb_restart = 1'b0;
        bus.i_spd_up = 1'b0;   bus.i_spd_down = 1'b0;  bus.i_spd_reset = 1'b0;
        bus.i_address_inc = 1'b0; bus.i_address_dec = 1'b0; bus.i_address_rst = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        bus.i_kb_play = 1'b1; bus.i_spd_up = 1'b1; bus.i_address_inc = 1'b1; bus.i_kb_bwd = 1'b1;
        cyc(); cyc(); cyc();
        n_cmp++; if (bus.o_flash_address !== 23'd0) begin n_err++; $display("FAIL reset_addr: got %0h expected 0", bus.o_flash_address); end
        n_cmp++; if (bus.o_sample_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", bus.o_sample_tick); end
        n_cmp++; if (bus.o_playing !== 1'b0) begin n_err++; $display("FAIL reset_playing: got %b expected 0", bus.o_playing); end
        n_cmp++; if (bus.o_direction !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %b expected 1", bus.o_direction); end
        n_cmp++; if (bus.o_divisor !== 16'd1136) begin n_err++; $display("FAIL reset_div: got %0d expected 1136", bus.o_divisor); end
        clear_inputs();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_tick_period();
        do_reset();
        bus.i_kb_play = 1'b1; cyc(); bus.i_kb_play = 1'b0;
        n_cmp++; if (bus.o_playing !== 1'b1) begin n_err++; $display("FAIL play_enter: got %b expected 1", bus.o_playing); end
        exp_q.delete();
        for (int k = 1; k <= 3; k++) exp_q.push_back(1136 * k);
        for (int n = 1; n <= 3 * 1136 + 20; n++) begin
            cyc();
            if (bus.o_sample_tick === 1'b1) begin
                int e;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL tick_unexpected: tick at cycle %0d expected none", n);
                end else begin
                    e = exp_q.pop_front();
                    if (n !== e) begin n_err++; $display("FAIL tick_time: got cycle %0d expected %0d", n, e); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL tick_missing: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_pause_hold();
        do_reset();
        bus.i_kb_play = 1'b1; cyc(); bus.i_kb_play = 1'b0;
        exp_q.delete();
        exp_q.push_back(2501 + 1136 - 500);
        for (int n = 1; n <= 3160; n++) begin
            bus.i_kb_pause = (n == 500);
            bus.i_kb_play  = (n == 2501);
            cyc();
            if (n == 1000) begin
                n_cmp++; if (bus.o_playing !== 1'b0) begin n_err++; $display("FAIL pause_state: got %b expected 0", bus.o_playing); end
            end
            if (bus.o_sample_tick === 1'b1) begin
                int e;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL pause_tick_unexpected: tick at cycle %0d expected none", n);
                end else begin
                    e = exp_q.pop_front();
                    if (n !== e) begin n_err++; $display("FAIL pause_tick_time: got cycle %0d expected %0d", n, e); end
                end
            end
        end
        clear_inputs();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pause_tick_missing: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_speed_change();
        do_reset();
        bus.i_kb_play = 1'b1; cyc(); bus.i_kb_play = 1'b0;
        exp_q.delete();
        exp_q.push_back(912);
        exp_q.push_back(912 + 496);
        for (int n = 1; n <= 1420; n++) begin
            bus.i_kb_pause = (n == 900);
            bus.i_spd_up   = (n >= 901) && (n <= 910);
            bus.i_kb_play  = (n == 911);
            cyc();
            if (n == 910) begin
                n_cmp++; if (bus.o_divisor !== 16'd496) begin n_err++; $display("FAIL speed_div: got %0d expected 496", bus.o_divisor); end
            end
            if (bus.o_sample_tick === 1'b1) begin
                int e;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL speed_tick_unexpected: tick at cycle %0d expected none", n);
                end else begin
                    e = exp_q.pop_front();
                    if (n !== e) begin n_err++; $display("FAIL speed_tick_time: got cycle %0d expected %0d", n, e); end
                end
            end
        end
        clear_inputs();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL speed_tick_missing: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_divisor_sat();
        int m;
        do_reset();
        m = 1136;
        exp_q.delete();
        for (int i = 0; i < 94; i++) begin
            clear_inputs();
            if (i < 20) begin
                bus.i_spd_up = 1'b1; m = (m - 64 < 284) ? 284 : m - 64;
            end else if (i < 22) begin
                bus.i_spd_up = 1'b1; bus.i_spd_down = 1'b1;
            end else if (i < 92) begin
                bus.i_spd_down = 1'b1; m = (m + 64 > 4544) ? 4544 : m + 64;
            end else if (i == 92) begin
                bus.i_spd_reset = 1'b1; bus.i_spd_up = 1'b1; m = 1136;
            end else begin
                bus.i_spd_down = 1'b1; m = m + 64;
            end
            exp_q.push_back(m);
            cyc();
            m = exp_q.pop_front();
            n_cmp++; if (bus.o_divisor !== m[15:0]) begin n_err++; $display("FAIL div_step%0d: got %0d expected %0d", i, bus.o_divisor, m); end
        end
        clear_inputs();
    endtask

    task automatic test_direction_step();
        int e;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.i_address_inc = 1'b1; exp_q.push_back(i); cyc();
            e = exp_q.pop_front();
            n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL fwd_inc%0d: got %0d expected %0d", i, bus.o_flash_address, e); end
        end
        clear_inputs();
        bus.i_kb_bwd = 1'b1; cyc(); bus.i_kb_bwd = 1'b0;
        n_cmp++; if (bus.o_direction !== 1'b0) begin n_err++; $display("FAIL dir_bwd: got %b expected 0", bus.o_direction); end
        n_cmp++; if (bus.o_flash_address !== 23'd5) begin n_err++; $display("FAIL dir_no_move: got %0d expected 5", bus.o_flash_address); end
        bus.i_address_inc = 1'b1; exp_q.push_back(4); cyc(); e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL bwd_inc: got %0d expected %0d", bus.o_flash_address, e); end
        bus.i_address_dec = 1'b1; exp_q.push_back(4); cyc(); e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL inc_dec_cancel: got %0d expected %0d", bus.o_flash_address, e); end
        bus.i_address_inc = 1'b0; exp_q.push_back(5); cyc(); e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL bwd_dec: got %0d expected %0d", bus.o_flash_address, e); end
        clear_inputs();
        bus.i_kb_fwd = 1'b1; bus.i_kb_bwd = 1'b1; cyc(); clear_inputs();
        n_cmp++; if (bus.o_direction !== 1'b0) begin n_err++; $display("FAIL dir_both: got %b expected 0", bus.o_direction); end
        bus.i_kb_fwd = 1'b1; cyc(); clear_inputs();
        bus.i_address_inc = 1'b1; exp_q.push_back(6); cyc(); e = exp_q.pop_front(); clear_inputs();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL fwd_again: got %0d expected %0d", bus.o_flash_address, e); end
    endtask

    task automatic test_restart();
        int e;
        do_reset();
        bus.i_kb_bwd = 1'b1; cyc(); clear_inputs();
        bus.i_kb_restart = 1'b1; bus.i_address_inc = 1'b1; exp_q.push_back(LAST); cyc(); clear_inputs();
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL restart_bwd: got %0h expected %0h", bus.o_flash_address, e); end
        bus.i_address_inc = 1'b1; exp_q.push_back(LAST - 1); cyc(); clear_inputs();
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL bwd_from_last: got %0h expected %0h", bus.o_flash_address, e); end
        bus.i_address_rst = 1'b1; exp_q.push_back(LAST); cyc(); clear_inputs();
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL addr_rst_bwd: got %0h expected %0h", bus.o_flash_address, e); end
        bus.i_kb_fwd = 1'b1; cyc(); clear_inputs();
        bus.i_address_rst = 1'b1; bus.i_address_dec = 1'b1; exp_q.push_back(0); cyc(); clear_inputs();
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_flash_address !== e[22:0]) begin n_err++; $display("FAIL addr_rst_fwd: got %0h expected %0h", bus.o_flash_address, e); end
    endtask

    task automatic test_end_of_image();
        logic [22:0] exp_a;
        logic        exp_p;
        do_reset();
        bus.i_kb_bwd = 1'b1; cyc(); clear_inputs();
        bus.i_kb_restart = 1'b1; cyc(); clear_inputs();
        bus.i_kb_fwd = 1'b1; cyc(); clear_inputs();
        bus.i_kb_play = 1'b1; cyc(); clear_inputs();
        n_cmp++; if (bus.o_playing !== 1'b1) begin n_err++; $display("FAIL end_pre_play: got %b expected 1", bus.o_playing); end
`ifdef PLAYBACK_LOOP_EN
        exp_a = 23'd0; exp_p = 1'b1;
`else
        exp_a = LAST;  exp_p = 1'b0;
`endif
        bus.i_address_inc = 1'b1; cyc(); clear_inputs();
        n_cmp++; if (bus.o_flash_address !== exp_a) begin n_err++; $display("FAIL end_fwd_addr: got %0h expected %0h", bus.o_flash_address, exp_a); end
        n_cmp++; if (bus.o_playing !== exp_p) begin n_err++; $display("FAIL end_fwd_play: got %b expected %b", bus.o_playing, exp_p); end
        bus.i_kb_play = 1'b1; cyc(); clear_inputs();
        n_cmp++; if (bus.o_playing !== 1'b1 || bus.o_flash_address !== exp_a) begin
            n_err++; $display("FAIL end_resume: got play %b addr %0h expected play 1 addr %0h", bus.o_playing, bus.o_flash_address, exp_a);
        end
        bus.i_kb_restart = 1'b1; cyc(); clear_inputs();
        bus.i_kb_bwd = 1'b1; cyc(); clear_inputs();
`ifdef PLAYBACK_LOOP_EN
        exp_a = LAST;  exp_p = 1'b1;
`else
        exp_a = 23'd0; exp_p = 1'b0;
`endif
        bus.i_address_inc = 1'b1; cyc(); clear_inputs();
        n_cmp++; if (bus.o_flash_address !== exp_a) begin n_err++; $display("FAIL end_bwd_addr: got %0h expected %0h", bus.o_flash_address, exp_a); end
        n_cmp++; if (bus.o_playing !== exp_p) begin n_err++; $display("FAIL end_bwd_play: got %b expected %b", bus.o_playing, exp_p); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_spd_down = 1'b1; cyc(); clear_inputs();
        bus.i_address_inc = 1'b1; cyc(); cyc(); cyc(); clear_inputs();
        bus.i_kb_bwd = 1'b1; cyc(); clear_inputs();
        bus.i_kb_play = 1'b1; cyc(); clear_inputs();
        repeat (1130) cyc();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.o_flash_address !== 23'd0 || bus.o_divisor !== 16'd1136 || bus.o_direction !== 1'b1) begin
            n_err++; $display("FAIL midrst_vals: got addr %0h div %0d dir %b expected 0 1136 1", bus.o_flash_address, bus.o_divisor, bus.o_direction);
        end
        n_cmp++; if (bus.o_playing !== 1'b0) begin n_err++; $display("FAIL midrst_play: got %b expected 0", bus.o_playing); end
        for (int n = 0; n < 30; n++) begin
            if (n == 10) rst = 1'b1;
            cyc();
            n_cmp++; if (bus.o_sample_tick !== 1'b0) begin n_err++; $display("FAIL midrst_tick: got %b expected 0 at cycle %0d", bus.o_sample_tick, n); end
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_tick_period();
        test_pause_hold();
        test_speed_change();
        test_divisor_sat();
        test_direction_step();
        test_restart();
        test_end_of_image();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
